// File: rtl/tof_sched_pkg.sv
// Shared types and defaults for the ToF interrupt scheduler.
package tof_sched_pkg;

   localparam int unsigned N_CH_DEF           = 8;
   localparam int unsigned CH_W_DEF           = $clog2(N_CH_DEF);
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

   typedef logic [CH_W_DEF-1:0] ch_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/tof_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending searching upward
// from ptr+1 with wrap-around, so the channel at ptr has lowest priority.
//   pending   : request vector
//   ptr       : last granted channel
//   gnt_vld_c : any request present
//   gnt_idx_c : winning channel
module tof_rr_arbiter
   import tof_sched_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEF
) (
   input  logic [N_CH-1:0]                           pending,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ptr,
   output logic                                      gnt_vld_c,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] gnt_idx_c
);

   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [CH_W-1:0] cand;

   // Scan from the farthest offset down so the nearest hit is assigned last.
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_idx_c = '0;
      cand      = '0;
      for (int i = int'(N_CH); i >= 1; i--) begin
         cand = CH_W'((int'(ptr) + i) % int'(N_CH));
         if (pending[cand]) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = cand;
         end
      end
   end

endmodule

// File: rtl/tof_int_scheduler.sv
// Scheduler for the eight-sensor ToF I2C subsystem. Synchronises the
// active-low data-ready pins, latches per-channel pending flags and grants
// one read at a time via req/ack/done, round-robin, with a hang timeout.
//   tof_int           : raw active-low sensor interrupts (async)
//   enable            : permits new grants
//   read_req/read_ch  : request and channel to the I2C modules
//   read_ack/done/err : handshake pulses back from the I2C modules
//   busy              : transaction in flight
//   pending/overrun/err_flags : per-channel status; flags_clr clears the sticky ones
//   timeout_evt       : one-cycle pulse when a transaction times out
module tof_int_scheduler
   import tof_sched_pkg::*;
#(
   parameter int unsigned N_CH           = N_CH_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [N_CH-1:0]                           tof_int,
   input  logic                                      enable,
   output logic                                      read_req,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] read_ch,
   input  logic                                      read_ack,
   input  logic                                      read_done,
   input  logic                                      read_err,
   output logic                                      busy,
   output logic [N_CH-1:0]                           pending,
   output logic [N_CH-1:0]                           overrun,
   output logic [N_CH-1:0]                           err_flags,
   input  logic [N_CH-1:0]                           flags_clr,
   output logic                                      timeout_evt
);

   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [N_CH-1:0]  sync0_q, sync1_q, hist_q;
   logic [N_CH-1:0]  fall_c, clr_hit_c, err_hit_c;
   logic [N_CH-1:0]  pending_d, pending_q;
   logic [N_CH-1:0]  overrun_d, overrun_q;
   logic [N_CH-1:0]  err_flags_d, err_flags_q;

   state_t           state_d, state_q;
   logic [TMR_W-1:0] timer_d, timer_q;
   logic [CH_W-1:0]  ptr_d, ptr_q;
   logic [CH_W-1:0]  read_ch_d, read_ch_q;
   logic             read_req_d, read_req_q;
   logic             busy_d, busy_q;
   logic             timeout_d, timeout_q;
   logic             ack_clr_c, err_set_c, timer_hit_c;
   logic             gnt_vld_c;
   logic [CH_W-1:0]  gnt_idx_c;

   // Synchroniser and history flops reset high so reset release is edge-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q <= '1;
         sync1_q <= '1;
         hist_q  <= '1;
      end else begin
         sync0_q <= tof_int;
         sync1_q <= sync0_q;
         hist_q  <= sync1_q;
      end
   end

   // Per-channel edge detect and status flag next-state.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign fall_c[g]      = hist_q[g] & ~sync1_q[g];
      assign clr_hit_c[g]   = ack_clr_c & (read_ch_q == CH_W'(g));
      assign err_hit_c[g]   = err_set_c & (read_ch_q == CH_W'(g));
      // A new edge wins over the ack-clear; that case is not an overrun.
      assign pending_d[g]   = fall_c[g] | (pending_q[g] & ~clr_hit_c[g]);
      assign overrun_d[g]   = (fall_c[g] & pending_q[g] & ~clr_hit_c[g])
                            | (overrun_q[g] & ~flags_clr[g]);
      assign err_flags_d[g] = err_hit_c[g] | (err_flags_q[g] & ~flags_clr[g]);
   end

   tof_rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .pending   (pending_q),
      .ptr       (ptr_q),
      .gnt_vld_c (gnt_vld_c),
      .gnt_idx_c (gnt_idx_c)
   );

   assign timer_hit_c = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

   // Grant FSM. A handshake completing in the timeout cycle takes priority.
   always_comb begin
      state_d   = state_q;
      timer_d   = (state_q == ST_IDLE) ? '0 : timer_q + TMR_W'(1);
      ptr_d     = ptr_q;
      read_ch_d = read_ch_q;
      timeout_d = 1'b0;
      ack_clr_c = 1'b0;
      err_set_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && gnt_vld_c) begin
               state_d   = ST_REQ;
               read_ch_d = gnt_idx_c;
               ptr_d     = gnt_idx_c;
               timer_d   = '0;
            end
         end
         ST_REQ: begin
            if (read_ack) begin
               ack_clr_c = 1'b1;
               state_d   = ST_WAIT;
            end else if (timer_hit_c) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (read_err) begin
               err_set_c = 1'b1;
               state_d   = ST_IDLE;
            end else if (read_done) begin
               state_d   = ST_IDLE;
            end else if (timer_hit_c) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      read_req_d = (state_d == ST_REQ);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         ptr_q       <= CH_W'(N_CH - 1);
         read_ch_q   <= '0;
         read_req_q  <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         pending_q   <= '0;
         overrun_q   <= '0;
         err_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         ptr_q       <= ptr_d;
         read_ch_q   <= read_ch_d;
         read_req_q  <= read_req_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         err_flags_q <= err_flags_d;
      end
   end

   assign read_req    = read_req_q;
   assign read_ch     = read_ch_q;
   assign busy        = busy_q;
   assign pending     = pending_q;
   assign overrun     = overrun_q;
   assign err_flags   = err_flags_q;
   assign timeout_evt = timeout_q;

endmodule

// File: tb/tb_tof_int_scheduler.sv
// Directed bench for tof_int_scheduler with a short timeout.
module tb_tof_int_scheduler;

   logic       clk;
   logic       rst_n;
   logic [7:0] tof_int;
   logic       enable;
   logic       read_req;
   logic [2:0] read_ch;
   logic       read_ack;
   logic       read_done;
   logic       read_err;
   logic       busy;
   logic [7:0] pending;
   logic [7:0] overrun;
   logic [7:0] err_flags;
   logic [7:0] flags_clr;
   logic       timeout_evt;

   int n_chk = 0;
   int n_err = 0;

   tof_int_scheduler #(
      .N_CH           (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tof_int     (tof_int),
      .enable      (enable),
      .read_req    (read_req),
      .read_ch     (read_ch),
      .read_ack    (read_ack),
      .read_done   (read_done),
      .read_err    (read_err),
      .busy        (busy),
      .pending     (pending),
      .overrun     (overrun),
      .err_flags   (err_flags),
      .flags_clr   (flags_clr),
      .timeout_evt (timeout_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance n clock edges, leaving time 1 unit after the last edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_ack();
      read_ack = 1'b1; tick(); read_ack = 1'b0;
   endtask

   task automatic do_done();
      read_done = 1'b1; tick(); read_done = 1'b0;
   endtask

   task automatic do_err();
      read_err = 1'b1; tick(); read_err = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin : stim
      int req_seen;
      rst_n     = 1'b0;
      tof_int   = 8'hFF;
      enable    = 1'b0;
      read_ack  = 1'b0;
      read_done = 1'b0;
      read_err  = 1'b0;
      flags_clr = 8'h00;

      // Reset values and quiet release
      tick(3);
      check("rst_req",  32'(read_req),    32'h0);
      check("rst_ch",   32'(read_ch),     32'h0);
      check("rst_busy", 32'(busy),        32'h0);
      check("rst_pend", 32'(pending),     32'h0);
      check("rst_ovr",  32'(overrun),     32'h0);
      check("rst_err",  32'(err_flags),   32'h0);
      check("rst_tmo",  32'(timeout_evt), 32'h0);
      rst_n  = 1'b1;
      enable = 1'b1;
      req_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (read_req || (pending != 8'h00)) req_seen++;
      end
      check("idle_quiet", 32'(req_seen), 32'h0);

      // Single channel 3: exact pin-to-request latency
      tof_int[3] = 1'b0;
      tick(3);
      check("c3_pend",    32'(pending),  32'h08);
      check("c3_req_early", 32'(read_req), 32'h0);
      tick();
      check("c3_req",  32'(read_req), 32'h1);
      check("c3_ch",   32'(read_ch),  32'h3);
      check("c3_busy", 32'(busy),     32'h1);
      do_ack();
      check("c3_ack_req",  32'(read_req), 32'h0);
      check("c3_ack_pend", 32'(pending),  32'h0);
      check("c3_ack_busy", 32'(busy),     32'h1);
      tof_int = 8'hFF;
      tick(2);
      check("c3_wait_busy", 32'(busy), 32'h1);
      do_done();
      check("c3_done_busy", 32'(busy), 32'h0);
      tick(3);

      // Round-robin: serve ch5 to park the pointer, then 1/5/6 together
      tof_int[5] = 1'b0;
      tick(4);
      check("rr_pre_ch", 32'(read_ch), 32'h5);
      do_ack();
      do_done();
      tof_int = 8'hFF;
      tick(3);
      tof_int = 8'b1001_1101;
      tick(3);
      check("rr_pend", 32'(pending), 32'h62);
      tick();
      check("rr_g1_req", 32'(read_req), 32'h1);
      check("rr_g1_ch",  32'(read_ch),  32'h6);
      do_ack();
      check("rr_g1_pend", 32'(pending), 32'h22);
      tick(2);
      check("rr_hold", 32'(read_req), 32'h0);
      do_done();
      check("rr_gap_req",  32'(read_req), 32'h0);
      check("rr_gap_busy", 32'(busy),     32'h0);
      tick();
      check("rr_g2_req", 32'(read_req), 32'h1);
      check("rr_g2_ch",  32'(read_ch),  32'h1);
      do_ack();
      do_done();
      tick();
      check("rr_g3_req", 32'(read_req), 32'h1);
      check("rr_g3_ch",  32'(read_ch),  32'h5);
      do_ack();
      do_done();
      tof_int = 8'hFF;
      tick(3);

      // Overrun on ch2 with grants held off
      enable = 1'b0;
      tof_int[2] = 1'b0;
      tick(3);
      check("ov_pend1", 32'(pending), 32'h04);
      check("ov_none",  32'(overrun), 32'h0);
      tof_int[2] = 1'b1;
      tick(3);
      tof_int[2] = 1'b0;
      tick(3);
      check("ov_set",     32'(overrun),  32'h04);
      check("ov_pend2",   32'(pending),  32'h04);
      check("ov_no_req",  32'(read_req), 32'h0);
      tick(5);
      check("ov_sticky",  32'(overrun),  32'h04);
      tof_int[2] = 1'b1;
      enable = 1'b1;
      tick();
      check("ov_req", 32'(read_req), 32'h1);
      check("ov_ch",  32'(read_ch),  32'h2);
      do_ack();
      check("ov_ack_pend", 32'(pending), 32'h0);
      flags_clr = 8'h04;
      tick();
      flags_clr = 8'h00;
      check("ov_clr", 32'(overrun), 32'h0);
      // New edge during WAIT re-pends without overrun
      tof_int[2] = 1'b0;
      tick(3);
      check("ov_wait_pend", 32'(pending), 32'h04);
      check("ov_wait_ovr",  32'(overrun), 32'h0);
      do_done();
      tof_int[2] = 1'b1;
      tick();
      check("ov_re_req", 32'(read_req), 32'h1);
      check("ov_re_ch",  32'(read_ch),  32'h2);
      tick(3);
      // Edge landing on the ack-clear cycle keeps pending, no overrun
      tof_int[2] = 1'b0;
      tick(2);
      read_ack = 1'b1;
      tick();
      read_ack = 1'b0;
      check("ov_coll_pend", 32'(pending), 32'h04);
      check("ov_coll_ovr",  32'(overrun), 32'h0);
      do_done();
      tick();
      do_ack();
      do_done();
      tof_int = 8'hFF;
      tick(3);

      // Timeout on ch0, retry, then error completion
      tof_int[0] = 1'b0;
      tick(4);
      check("to_req", 32'(read_req), 32'h1);
      check("to_ch",  32'(read_ch),  32'h0);
      tick(15);
      check("to_early_evt", 32'(timeout_evt), 32'h0);
      check("to_early_req", 32'(read_req),    32'h1);
      tick();
      check("to_evt",      32'(timeout_evt), 32'h1);
      check("to_drop_req", 32'(read_req),    32'h0);
      check("to_busy",     32'(busy),        32'h0);
      check("to_pend",     32'(pending),     32'h01);
      tick();
      check("to_evt_end", 32'(timeout_evt), 32'h0);
      check("to_retry",   32'(read_req),    32'h1);
      check("to_retry_ch", 32'(read_ch),    32'h0);
      do_ack();
      tick(2);
      read_err  = 1'b1;
      read_done = 1'b1;
      tick();
      read_err  = 1'b0;
      read_done = 1'b0;
      check("er_flag", 32'(err_flags), 32'h01);
      check("er_busy", 32'(busy),      32'h0);
      check("er_pend", 32'(pending),   32'h0);
      tick(3);
      check("er_sticky", 32'(err_flags), 32'h01);
      check("er_no_req", 32'(read_req),  32'h0);
      flags_clr = 8'h01;
      tick();
      flags_clr = 8'h00;
      check("er_clr", 32'(err_flags), 32'h0);
      // Stray handshake pulses in IDLE are ignored
      do_err();
      do_ack();
      check("stray_err",  32'(err_flags), 32'h0);
      check("stray_busy", 32'(busy),      32'h0);
      tof_int = 8'hFF;
      tick(3);

      // Reset during WAIT
      tof_int = 8'b0110_1111;
      tick(3);
      check("rs_pend", 32'(pending), 32'h90);
      tick();
      check("rs_ch", 32'(read_ch), 32'h4);
      do_ack();
      check("rs_ack_pend", 32'(pending), 32'h80);
      tick();
      rst_n = 1'b0;
      #1;
      check("rs_async_req",  32'(read_req), 32'h0);
      check("rs_async_busy", 32'(busy),     32'h0);
      check("rs_async_pend", 32'(pending),  32'h0);
      tof_int = 8'hFF;
      tick(3);
      rst_n = 1'b1;
      req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (read_req || (pending != 8'h00)) req_seen++;
      end
      check("rs_quiet", 32'(req_seen), 32'h0);
      tof_int[7] = 1'b0;
      tick(4);
      check("rs_new_req", 32'(read_req), 32'h1);
      check("rs_new_ch",  32'(read_ch),  32'h7);
      do_ack();
      do_done();
      check("rs_end_busy", 32'(busy), 32'h0);
      tof_int = 8'hFF;
      tick(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tof_int_scheduler.md
# tof_int_scheduler

Upstream scheduler for the eight-sensor ToF I2C subsystem. It watches the raw active-low ToF_INT data-ready lines, synchronises them and latches a pending flag per sensor. It grants one read at a time to the I2C communication modules through a request/acknowledge/done handshake, using round-robin order. It also flags overruns, errors and hung transactions for the control logic.

## Interface
Parameters:
- N_CH, 8, number of ToF sensor channels
- TIMEOUT_CYCLES, 1_000_000, cycles allowed from grant to done/err (10 ms at 100 MHz)

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  reset; asynchronous, active-low
- tof_int  input  N_CH  raw sensor interrupt pins, asynchronous, active-low, idle high
- enable  input  1  permits new grants; in-flight transaction always completes
- read_req  output  1  read request to I2C modules
- read_ch  output  $clog2(N_CH)  channel to read; valid while read_req or busy
- read_ack  input  1  I2C modules accepted request (single-cycle pulse)
- read_done  input  1  read finished OK (pulse)
- read_err  input  1  read finished with NACK/bus error (pulse)
- busy  output  1  transaction in flight (REQ or WAIT)
- pending  output  N_CH  latched data-ready per channel
- overrun  output  N_CH  sticky: new interrupt while already pending
- err_flags  output  N_CH  sticky: read_err returned for channel
- flags_clr  input  N_CH  clears overrun[i] and err_flags[i]
- timeout_evt  output  1  one-cycle pulse on transaction timeout

## Operation
- Reset values: read_req 0, read_ch 0, busy 0, pending 0, overrun 0, err_flags 0, timeout_evt 0, FSM IDLE, RR pointer N_CH-1 (ch0 served first), timer 0.
- Synchroniser flops reset to 1 so that reset release never produces a false edge.
- Per channel: 2-flop synchroniser, then a history flop. Falling edge = history 1 and sync 0. A level held low does not re-trigger.
- Edge on ch i sets pending[i]. If pending[i] is already 1 and not being cleared this cycle, overrun[i] is set as well.
- FSM states:
  - IDLE: when enable=1 and |pending, pick the first pending channel searching from pointer+1 with wrap-around. Register read_ch, set read_req=1 and the pointer to that channel, go to REQ.
  - REQ: hold read_req and read_ch stable until read_ack. On ack: read_req=0, clear pending[read_ch], go to WAIT.
  - WAIT: on read_done go to IDLE. On read_err set err_flags[read_ch] and go to IDLE. done and err together count as err.
- Timer: cleared on entering REQ and counts in REQ and WAIT. When it reaches TIMEOUT_CYCLES-1: pulse timeout_evt, drop read_req, go to IDLE. pending[read_ch] is left as is, so an un-acked request is retried.
- Simultaneous events:
  - Edge on ch i in the same cycle as its ack-clear: pending[i] stays 1, no overrun.
  - flags_clr[i] together with a new set event: set wins.
- Handshake inputs arriving outside the expected state are ignored.
- enable=0 blocks only the IDLE→REQ transition.
- Reset mid-transaction: everything returns to reset values immediately. read_req drops asynchronously.

## Timing
- Pin falling edge, captured at clock edge k: sync0 after k, sync1 after k+1, pending set at k+2, read_req high at k+3.
- Pin to read_req latency is 4 edges with the FSM idle and the channel winning arbitration.
- read_ack at edge a: read_req low and pending cleared after a, busy still 1.
- read_done at edge d: busy low after d. The earliest next read_req is after d+1, so there is at least one idle cycle between transactions.
- All outputs are registered.

## Structure
- Package tof_sched_pkg: N_CH default, ch_idx_t typedef, state enum {IDLE, REQ, WAIT}, default TIMEOUT_CYCLES.
- Sub-module tof_rr_arbiter: combinational round-robin pick (pending, pointer) → grant valid + index. Reused later for ToF data readout muxing.
- Synchroniser/edge logic stays inline, in a generate loop over N_CH.

## Test plan
- Reset release with tof_int all high: no pending bits, read_req stays 0 for 100 cycles.
- Falling edge on ch3 only: read_req=1 and read_ch=3 exactly 4 edges after the pin falls. ack clears pending[3]. done returns busy to 0.
- Edges on ch1, ch5 and ch6 together, pointer at 5: grants in order 6, 1, 5, each only after the previous done.
- Second ch2 edge before its grant: overrun[2]=1 and stays set until flags_clr[2]. A second edge during the ch2 WAIT sets pending[2] again with no overrun.
- Grant ch0 with no ack, TIMEOUT_CYCLES=16: timeout_evt pulses once after 16 cycles and ch0 is re-requested. read_err on a later attempt sets err_flags[0].
- Assert rst_n low during WAIT: read_req, busy and pending go to 0 immediately. No grant appears until a new edge occurs after release.
